// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU boot path: loader FSM encoding and data widths.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } ldr_state_e;

endpackage : cpu_pkg

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles a checksummed byte frame into 16-bit
// words, writes them to consecutive I_memory addresses and releases the CPU on success.
module imem_loader
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] words
);

  ldr_state_e        state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [WORD_W-1:0] words_q, words_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              rx_state;
  logic              accept;
  logic [WORD_W-1:0] cnt_full;

  // Byte intake is open in every frame-parsing state unless a restart is being requested.
  assign rx_state = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                    (state_q == S_DAT_HI) || (state_q == S_DAT_LO) ||
                    (state_q == S_CHK);
  assign in_ready = rx_state && !start;
  assign accept   = in_valid && in_ready;
  assign cnt_full = {cnt_q[WORD_W-1:BYTE_W], in_data};

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q     <= S_CNT_HI;
      cnt_q       <= '0;
      hi_q        <= '0;
      xor_q       <= '0;
      words_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      xor_q       <= xor_d;
      words_q     <= words_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    xor_d     = xor_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // A restart wins over any byte offered in the same cycle.
    if (start) begin
      state_d   = S_CNT_HI;
      cnt_d     = '0;
      xor_d     = '0;
      words_d   = '0;
      wr_addr_d = BASE_ADDR;
    end else if (accept) begin
      case (state_q)
        S_CNT_HI: begin
          cnt_d   = {in_data, BYTE_W'(0)};
          xor_d   = xor_q ^ in_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_d = cnt_full;
          xor_d = xor_q ^ in_data;
          if (32'(cnt_full) > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (cnt_full == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_HI;
          end
        end
        S_DAT_HI: begin
          hi_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
          xor_d     = xor_q ^ in_data;
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + words_q;
          wr_data_d = {hi_q, in_data};
          words_d   = words_q + WORD_W'(1);
          state_d   = (words_q + WORD_W'(1) == cnt_q) ? S_CHK : S_DAT_HI;
        end
        S_CHK: begin
          state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign done      = done_q;
  assign err       = err_q;
  assign words     = words_q;

endmodule : imem_loader
